// File: rtl/rgbw_pkg.sv
// Shared definitions for the RGBW frame sequencer.
//   state_t     : frame FSM states
//   SYNC_BYTE   : frame start marker
//   FRAME_LEN   : bytes per frame including the sync byte
//   PAYLOAD_LEN : data bytes following the sync byte
//   IDX_*       : position of each field in the staging/committed banks
package rgbw_pkg;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_COLLECT,
        ST_PENDING
    } state_t;

    localparam logic [7:0]  SYNC_BYTE   = 8'h55;
    localparam int unsigned FRAME_LEN   = 8;
    localparam int unsigned PAYLOAD_LEN = FRAME_LEN - 1;

    localparam int unsigned IDX_LINT  = 0;
    localparam int unsigned IDX_COLOR = 1;
    localparam int unsigned IDX_RED   = 2;
    localparam int unsigned IDX_GREEN = 3;
    localparam int unsigned IDX_BLUE  = 4;
    localparam int unsigned IDX_WHITE = 5;
    localparam int unsigned IDX_MODE  = 6;

endpackage

// File: rtl/rgbw_rdy_sync.sv
// Byte-ready synchroniser: brings the SPI slave's asynchronous rx_rdy level into
// the clk domain and emits a single-cycle strobe per rising edge.
//   clk      in  system clock
//   reset    in  synchronous, active-low reset
//   async_in in  asynchronous ready level
//   strobe   out one-cycle pulse, high during the third clock after async_in rises
module rgbw_rdy_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic strobe
);

    // [0],[1]: metastability chain; [2]: previous synchronised value for edge detect
    logic [2:0] shift;

    always_ff @(posedge clk) begin
        if (!reset) begin
            shift <= '0;
        end else begin
            shift <= {shift[1:0], async_in};
        end
    end

    assign strobe = shift[1] & ~shift[2];

endmodule

// File: rtl/rgbw_frame_sequencer.sv
// Frame-level controller for the SPI command link. Hunts for the sync byte,
// collects the 7-byte payload into a staging bank, and commits the whole bank
// atomically to the colour/PWM datapath.
//   clk, reset              clock / synchronous active-low reset
//   rx_byte, rx_rdy         SPI byte and its asynchronous ready level
//   pwm_period_end          one-cycle pulse at PWM counter wrap (commit point)
//   lint..mode              committed frame fields
//   frame_ok / frame_err    one-cycle pulses on commit / timeout abort
//   busy                    high whenever not hunting for a sync byte
//   byte_cnt                bytes accepted in the current frame (0..FRAME_LEN)
module rgbw_frame_sequencer
    import rgbw_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC      = 50000,
    parameter bit          COMMIT_ON_PERIOD = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_rdy,
    input  logic       pwm_period_end,
    output logic [7:0] lint,
    output logic [7:0] color_idx,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic [7:0] white,
    output logic [7:0] mode,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       busy,
    output logic [3:0] byte_cnt
);

    logic strobe;

    rgbw_rdy_sync u_rdy_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (rx_rdy),
        .strobe   (strobe)
    );

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [16:0] tmo, tmo_n;
    logic [7:0]  stage     [PAYLOAD_LEN];
    logic [7:0]  stage_n   [PAYLOAD_LEN];
    logic [7:0]  committed [PAYLOAD_LEN];
    logic        commit;
    logic        abort;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tmo_n   = tmo;
        stage_n = stage;
        commit  = 1'b0;
        abort   = 1'b0;

        unique case (state)
            ST_HUNT: begin
                tmo_n = '0;
                if (strobe && rx_byte == SYNC_BYTE) begin
                    state_n = ST_COLLECT;
                    cnt_n   = 4'd1;
                end
            end

            ST_COLLECT: begin
                if (strobe) begin
                    tmo_n = '0;
                    for (int unsigned i = 0; i < PAYLOAD_LEN; i++) begin
                        if (cnt == 4'(i + 1)) stage_n[i] = rx_byte;
                    end
                    cnt_n = cnt + 4'd1;
                    if (cnt_n == 4'(FRAME_LEN)) begin
                        if (COMMIT_ON_PERIOD) begin
                            state_n = ST_PENDING;
                        end else begin
                            // stage_n already holds the last byte, so commit it directly
                            commit  = 1'b1;
                            cnt_n   = '0;
                            state_n = ST_HUNT;
                        end
                    end
                end else if (tmo == 17'(TIMEOUT_CYC - 1)) begin
                    abort   = 1'b1;
                    state_n = ST_HUNT;
                    cnt_n   = '0;
                    tmo_n   = '0;
                    stage_n = '{default: '0};
                end else begin
                    tmo_n = tmo + 17'd1;
                end
            end

            ST_PENDING: begin
                tmo_n = '0;
                // An early byte (overrun) forces the commit, then is treated as a hunt byte
                if (strobe || pwm_period_end) begin
                    commit  = 1'b1;
                    cnt_n   = '0;
                    state_n = ST_HUNT;
                    if (strobe && rx_byte == SYNC_BYTE) begin
                        state_n = ST_COLLECT;
                        cnt_n   = 4'd1;
                    end
                end
            end

            default: begin
                state_n = ST_HUNT;
                cnt_n   = '0;
                tmo_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_HUNT;
            cnt       <= '0;
            tmo       <= '0;
            stage     <= '{default: '0};
            committed <= '{default: '0};
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            tmo       <= tmo_n;
            stage     <= stage_n;
            frame_ok  <= commit;
            frame_err <= abort;
            if (commit) committed <= stage_n;
        end
    end

    assign lint      = committed[IDX_LINT];
    assign color_idx = committed[IDX_COLOR];
    assign red       = committed[IDX_RED];
    assign green     = committed[IDX_GREEN];
    assign blue      = committed[IDX_BLUE];
    assign white     = committed[IDX_WHITE];
    assign mode      = committed[IDX_MODE];
    assign busy      = (state != ST_HUNT);
    assign byte_cnt  = cnt;

endmodule

// File: tb/tb_rgbw_frame_sequencer.sv
module tb_rgbw_frame_sequencer;

    localparam int unsigned TMO = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_byte = '0;
    logic       rx_rdy = 1'b0;
    logic       pwm = 1'b0;
    logic [7:0] rx_byte_b = '0;
    logic       rx_rdy_b = 1'b0;

    logic [7:0] lint, color_idx, red, green, blue, white, mode;
    logic       frame_ok, frame_err, busy;
    logic [3:0] byte_cnt;

    logic [7:0] lint_b, color_idx_b, red_b, green_b, blue_b, white_b, mode_b;
    logic       frame_ok_b, frame_err_b, busy_b;
    logic [3:0] byte_cnt_b;

    rgbw_frame_sequencer #(
        .TIMEOUT_CYC      (TMO),
        .COMMIT_ON_PERIOD (1'b1)
    ) dut (
        .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_rdy(rx_rdy),
        .pwm_period_end(pwm),
        .lint(lint), .color_idx(color_idx), .red(red), .green(green),
        .blue(blue), .white(white), .mode(mode),
        .frame_ok(frame_ok), .frame_err(frame_err), .busy(busy), .byte_cnt(byte_cnt)
    );

    rgbw_frame_sequencer #(
        .TIMEOUT_CYC      (TMO),
        .COMMIT_ON_PERIOD (1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .rx_byte(rx_byte_b), .rx_rdy(rx_rdy_b),
        .pwm_period_end(pwm),
        .lint(lint_b), .color_idx(color_idx_b), .red(red_b), .green(green_b),
        .blue(blue_b), .white(white_b), .mode(mode_b),
        .frame_ok(frame_ok_b), .frame_err(frame_err_b), .busy(busy_b), .byte_cnt(byte_cnt_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // pulse monitors (pulses span a full cycle, so each negedge sees them once)
    int ok_seen = 0, err_seen = 0, both_seen = 0, ok_seen_b = 0, err_seen_b = 0;
    always @(negedge clk) begin
        if (frame_ok)  ok_seen++;
        if (frame_err) err_seen++;
        if (frame_ok && frame_err) both_seen++;
        if (frame_ok_b)  ok_seen_b++;
        if (frame_err_b) err_seen_b++;
    end

    // reference model: a frame is a sync byte followed by 7 data bytes, held
    // until a period end or the next byte, then published all at once
    int         m_cnt = 0;
    bit         m_pend = 0;
    logic [7:0] m_stage[$];
    logic [7:0] m_out[7];
    int         m_ok = 0, m_err = 0;

    function automatic logic [55:0] m_pack();
        return {m_out[0], m_out[1], m_out[2], m_out[3], m_out[4], m_out[5], m_out[6]};
    endfunction

    function automatic void m_commit();
        for (int i = 0; i < 7; i++) m_out[i] = m_stage[i];
        m_ok++;
        m_pend = 0;
        m_cnt = 0;
    endfunction

    function automatic void m_byte(logic [7:0] b);
        if (m_pend) m_commit();
        if (m_cnt == 0) begin
            if (b == 8'h55) begin
                m_cnt = 1;
                m_stage.delete();
            end
        end else begin
            m_stage.push_back(b);
            m_cnt++;
            if (m_cnt == 8) m_pend = 1;
        end
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 7; i++) m_out[i] = '0;
        m_cnt = 0;
        m_pend = 0;
        m_stage.delete();
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_byte_cnt"}, 64'(byte_cnt), 64'(m_cnt));
        chk({tag, "_busy"}, 64'(busy), 64'(m_cnt != 0 || m_pend));
        chk({tag, "_outputs"}, 64'({lint, color_idx, red, green, blue, white, mode}), 64'(m_pack()));
        chk({tag, "_ok_count"}, 64'(ok_seen), 64'(m_ok));
        chk({tag, "_err_count"}, 64'(err_seen), 64'(m_err));
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_byte = b;
        rx_rdy = 1'b1;
        repeat (4) @(negedge clk);
        rx_rdy = 1'b0;
        repeat (4) @(negedge clk);
        m_byte(b);
    endtask

    task automatic period_end();
        @(negedge clk);
        pwm = 1'b1;
        @(negedge clk);
        pwm = 1'b0;
        @(negedge clk);
        if (m_pend) m_commit();
    endtask

    task automatic send_random_payload();
        for (int i = 0; i < 7; i++) send(8'($urandom_range(0, 255)));
    endtask

    // sends one byte to the commit-on-last-byte instance; lat = negedges until frame_ok (or -1)
    task automatic send_b(input logic [7:0] b, output int lat);
        lat = -1;
        @(negedge clk);
        rx_byte_b = b;
        rx_rdy_b = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (frame_ok_b && lat < 0) lat = i;
            if (i == 4) rx_rdy_b = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] junk;
        logic [7:0] pay[7];
        int lat;

        // reset state
        m_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        chk("reset_frame_ok", 64'(frame_ok), 64'd0);
        chk("reset_b_busy", 64'(busy_b), 64'd0);
        reset = 1'b1;

        // directed frame with known contents
        send(8'h55); send(8'h10); send(8'h02); send(8'hAA);
        send(8'hBB); send(8'hCC); send(8'hDD); send(8'h03);
        check_all("t1_pending");
        chk("t1_hold_before_period", 64'(lint), 64'd0);
        period_end();
        check_all("t1_commit");
        chk("t1_literal", 64'({lint, color_idx, red, green, blue, white, mode}), 64'h1002AABBCCDD03);

        // junk before sync is dropped
        send(8'h00);
        check_all("t2_junk0");
        send(8'h13);
        check_all("t2_junk1");
        send(8'h55);
        check_all("t2_sync");
        send_random_payload();
        period_end();
        check_all("t2_commit");

        // timeout mid-frame
        send(8'h55); send(8'h11); send(8'h22);
        check_all("t3_partial");
        repeat (TMO + 20) @(negedge clk);
        m_cnt = 0;
        m_stage.delete();
        m_err++;
        check_all("t3_timeout");

        // overrun: next sync forces the commit
        send(8'h55);
        send_random_payload();
        check_all("t4_pending");
        send(8'h55);
        check_all("t4_overrun");
        chk("t4_byte_cnt_one", 64'(byte_cnt), 64'd1);
        send_random_payload();
        period_end();
        check_all("t4_commit");

        // reset mid-frame
        send(8'h55); send(8'h21); send(8'h22); send(8'h23);
        check_all("t5_partial");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m_reset();
        check_all("t5_reset");
        send(8'h55);
        send_random_payload();
        period_end();
        check_all("t5_after");

        // randomized frames: junk, payloads that may contain the sync value,
        // commits by period end or by overrun
        for (int f = 0; f < 8; f++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == 8'h55) junk = 8'h54;
                send(junk);
            end
            send(8'h55);
            for (int i = 0; i < 7; i++) begin
                if ($urandom_range(0, 3) == 0) send(8'h55);
                else send(8'($urandom_range(0, 255)));
            end
            check_all("rand_frame");
            if ($urandom_range(0, 1) == 1) begin
                period_end();
                check_all("rand_commit");
            end
        end
        if (m_pend) period_end();
        check_all("rand_end");

        // commit-on-last-byte instance: frame_ok right after the last strobe
        for (int i = 0; i < 7; i++) pay[i] = 8'($urandom_range(0, 255));
        send_b(8'h55, lat);
        chk("cop0_sync_no_ok", 64'(lat), 64'(-1));
        for (int i = 0; i < 6; i++) send_b(pay[i], lat);
        chk("cop0_early_no_ok", 64'(ok_seen_b), 64'd0);
        send_b(pay[6], lat);
        chk("cop0_latency", 64'(lat), 64'd3);
        chk("cop0_ok_count", 64'(ok_seen_b), 64'd1);
        chk("cop0_outputs", 64'({lint_b, color_idx_b, red_b, green_b, blue_b, white_b, mode_b}),
            64'({pay[0], pay[1], pay[2], pay[3], pay[4], pay[5], pay[6]}));
        chk("cop0_idle", 64'({busy_b, byte_cnt_b}), 64'd0);
        chk("cop0_no_err", 64'(err_seen_b), 64'd0);

        chk("ok_err_exclusive", 64'(both_seen), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
